// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters: combinational lookup in IF, registered update in ID.
// Optional statistics counters are compiled in when BP_STATS_EN is defined.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_if,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              upd_mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0]       stat_updates,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_WT  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_WNT = CNT_WT - CNT_W'(1);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             unused_lsbs;

  // Word-aligned PCs: the two byte-offset bits take no part in indexing or tagging
  assign unused_lsbs = ^{pc_if[1:0], upd_pc[1:0]};

  assign lk_idx = pc_if[IDX_W+1:2];
  assign lk_tag = pc_if[ADDR_W-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[ADDR_W-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && cnt_q[lk_idx][CNT_W-1];
  assign pred_target = pred_taken ? target_q[lk_idx] : pc_if + PC_STEP;

  assign upd_mispredict = upd_valid &&
                          ((upd_taken != upd_pred_taken) ||
                           (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));

  // Lookup reads these arrays directly, so a same-cycle update is seen only on the next cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          cnt_q[up_idx]    <= sat_inc(cnt_q[up_idx]);
          target_q[up_idx] <= upd_target;
        end else begin
          cnt_q[up_idx] <= sat_dec(cnt_q[up_idx]);
        end
      end else if (upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        cnt_q[up_idx]    <= CNT_WT;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_valid)      stat_updates     <= stat_updates + 32'd1;
      if (upd_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the 5-stage pipeline: branch target buffer (BTB) with per-entry saturating counters.
- Lookup in IF: combinational read on the fetch PC; predicted next PC feeds the PC mux.
- Update in ID, where branches resolve. Produces a mispredict flag used to flush IF/ID and redirect the PC.
- Successor to the static predict-not-taken scheme. Generalised in table depth, address width and counter width.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, >= 2. Derived IDX_W = log2(ENTRIES).
- ADDR_W, 32, PC/target width.
- CNT_W, 2, saturating counter width, >= 1. Counter MSB = predict taken.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- pc_if  in  ADDR_W  fetch-stage PC.
- pred_hit  out  1  BTB hit on pc_if.
- pred_taken  out  1  predicted taken.
- pred_target  out  ADDR_W  predicted next PC.
- upd_valid  in  1  resolved branch in ID this cycle; pipeline gates it low on flush/stall.
- upd_pc  in  ADDR_W  PC of the resolving branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  ADDR_W  actual taken target.
- upd_pred_taken  in  1  prediction carried with the instruction through IF/ID.
- upd_pred_target  in  ADDR_W  predicted target carried through IF/ID.
- upd_mispredict  out  1  combinational; redirect/flush request.

Behaviour:
- Addressing:
  - index = pc[IDX_W+1:2];
  - tag = pc[ADDR_W-1:IDX_W+2].
  - PC[1:0] is ignored.
- Entry state: valid, tag, target, counter[CNT_W-1:0].
- Lookup is purely combinational from registered state, with no added latency:
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & counter MSB.
  - pred_target = pred_taken ? entry target : pc_if + 4 (modulo 2^ADDR_W).
- upd_mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & upd_target != upd_pred_target)).
  - Forced to 0 when upd_valid = 0.
- Update, registered at the clk edge when upd_valid = 1:
  - Hit on upd_pc, taken: counter += 1, saturating at 2^CNT_W-1; target <= upd_target.
  - Hit on upd_pc, not taken: counter -= 1, saturating at 0; target unchanged.
  - Miss, taken: allocate the indexed slot, overwriting any aliasing entry. Sets valid=1, tag, target=upd_target, counter=2^(CNT_W-1) (weakly taken).
  - Miss, not taken: no state change.
- Update and lookup on the same entry in the same cycle: lookup returns the pre-update value. No bypass.
- Reset (reset == 0 at the clk edge):
  - All valid=0, counters=2^(CNT_W-1)-1 (weakly not taken), targets=0, tags=0.
  - Reset dominates a simultaneous upd_valid.
  - Outputs after reset: pred_hit=0, pred_taken=0, pred_target=pc_if+4, upd_mispredict follows inputs.
- CNT_W=1: counter is a single last-outcome bit.
  - Taken sets it; not taken clears it; allocate sets it to 1; reset clears it to 0.
- No other state; direct-mapped, no replacement policy.

Optional Feature:
- Macro BP_STATS_EN.
- When defined, adds outputs stat_updates[31:0] and stat_mispredicts[31:0]:
  - Both zero on reset.
  - stat_updates increments on each upd_valid cycle; stat_mispredicts increments on each upd_mispredict cycle.
  - Both wrap modulo 2^32.
- When undefined, the ports and counters are absent; predictor behaviour is identical.

Test Plan:
- Defaults ENTRIES=16, CNT_W=2, so PC 0x40 maps to index 0, tag 1.
- Reset, then pc_if=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44.
- upd_valid, upd_pc=0x40, upd_taken=1, upd_target=0x100, upd_pred_taken=0 -> upd_mispredict=1 that cycle. Next cycle pc_if=0x40 -> pred_hit=1, pred_taken=1, pred_target=0x100.
- Counter saturation on the 0x40 entry:
  - Two not-taken updates -> counter 2->1->0. pred_taken=0, pred_target=0x44, pred_hit=1.
  - Then 4 taken updates -> counter saturates at 3.
  - One not-taken update -> counter 2, pred_taken still 1.
- Alias: taken update upd_pc=0x80 (index 0, tag 2), target 0x200 -> pc_if=0x40 misses; pc_if=0x80 hits, predicting 0x200.
- Target mismatch: upd_pred_taken=1, upd_pred_target=0x100, upd_taken=1, upd_target=0x104 -> upd_mispredict=1; next lookup returns 0x104.
- reset=0 in the same cycle as a taken upd_valid -> entry not allocated; next lookup pred_hit=0.
- With BP_STATS_EN: the above sequence yields the expected stat_updates and stat_mispredicts counts; both are 0 after reset.
